// File: rtl/im_arbiter.sv
// Two-port arbiter in front of the single-port instruction memory: fetch and
// loader share the array via round-robin, with a bounded locked burst for the loader.
module im_arbiter #(
  parameter int DEPTH_W   = 10,
  parameter int MAX_BURST = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               f_req,
  input  logic [31:0]        f_addr,
  output logic               f_gnt,
  output logic               f_rvalid,
  output logic [31:0]        f_rdata,
  output logic               f_err,
  input  logic               l_req,
  input  logic               l_we,
  input  logic [31:0]        l_addr,
  input  logic [31:0]        l_wdata,
  input  logic               l_lock,
  output logic               l_gnt,
  output logic               l_rvalid,
  output logic [31:0]        l_rdata,
  output logic               l_err,
  output logic [DEPTH_W-1:0] mem_addr,
  output logic               mem_we,
  output logic [31:0]        mem_wdata,
  input  logic [31:0]        mem_rdata
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

  typedef enum logic {ST_ARB, ST_BURST} state_t;

  state_t           r_state;
  logic             r_prio;
  logic [CNT_W-1:0] r_burst_cnt;
  logic             r_f_rvalid;
  logic [31:0]      r_f_rdata;
  logic             r_f_err;
  logic             r_l_rvalid;
  logic [31:0]      r_l_rdata;
  logic             r_l_err;

  logic             w_f_gnt;
  logic             w_l_gnt;
  logic             w_any_gnt;
  logic             w_misaligned;
  logic [31:0]      w_addr;
  logic             w_unused_hi;

  // Grants are gated by reset so nothing is accepted while state is being cleared.
  always_comb begin
    w_f_gnt = 1'b0;
    w_l_gnt = 1'b0;
    if (reset) begin
      if (r_state == ST_ARB) begin
        if (l_req && (!f_req || r_prio)) begin
          w_l_gnt = 1'b1;
        end else if (f_req) begin
          w_f_gnt = 1'b1;
        end
      end else begin
        if (l_req && ((r_burst_cnt < MAX_CNT) || !f_req)) begin
          w_l_gnt = 1'b1;
        end else if (f_req) begin
          w_f_gnt = 1'b1;
        end
      end
    end
  end

  assign w_any_gnt    = w_f_gnt | w_l_gnt;
  assign w_addr       = w_l_gnt ? l_addr : f_addr;
  assign w_misaligned = (w_addr[1:0] != 2'b00);
  // Upper address bits are dropped on purpose: accesses wrap within the array.
  assign w_unused_hi  = ^w_addr[31:DEPTH_W+2];

  assign mem_addr  = w_any_gnt ? w_addr[DEPTH_W+1:2] : '0;
  assign mem_we    = w_l_gnt & l_we & ~w_misaligned;
  assign mem_wdata = w_any_gnt ? l_wdata : '0;

  assign f_gnt    = w_f_gnt;
  assign l_gnt    = w_l_gnt;
  assign f_rvalid = r_f_rvalid;
  assign f_rdata  = r_f_rdata;
  assign f_err    = r_f_err;
  assign l_rvalid = r_l_rvalid;
  assign l_rdata  = r_l_rdata;
  assign l_err    = r_l_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_ARB;
      r_prio      <= 1'b0;
      r_burst_cnt <= '0;
      r_f_rvalid  <= 1'b0;
      r_f_rdata   <= '0;
      r_f_err     <= 1'b0;
      r_l_rvalid  <= 1'b0;
      r_l_rdata   <= '0;
      r_l_err     <= 1'b0;
    end else begin
      r_f_rvalid <= w_f_gnt;
      r_l_rvalid <= w_l_gnt;
      if (w_f_gnt) begin
        r_f_err   <= w_misaligned;
        r_f_rdata <= w_misaligned ? 32'h0 : mem_rdata;
      end
      if (w_l_gnt) begin
        r_l_err   <= w_misaligned;
        r_l_rdata <= w_misaligned ? 32'h0 : (l_we ? l_wdata : mem_rdata);
      end
      if (w_f_gnt) begin
        r_prio <= 1'b1;
      end else if (w_l_gnt) begin
        r_prio <= 1'b0;
      end
      case (r_state)
        ST_ARB: begin
          if (w_l_gnt && l_lock) begin
            r_state     <= ST_BURST;
            r_burst_cnt <= CNT_W'(1);
          end
        end
        default: begin
          if (w_l_gnt && l_lock) begin
            if (r_burst_cnt != MAX_CNT) begin
              r_burst_cnt <= r_burst_cnt + CNT_W'(1);
            end
          end else begin
            // Burst ends; an exit with nobody granted leaves fetch favoured.
            r_state     <= ST_ARB;
            r_burst_cnt <= '0;
            if (!w_f_gnt) begin
              r_prio <= 1'b0;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_im_arbiter.sv
// Bench for im_arbiter: directed scenarios plus random traffic, checked every
// cycle against a transaction-level model of grants, responses and array contents.
module tb_im_arbiter;
  localparam int DW = 10;
  localparam int MB = 8;
  localparam int NW = 1 << DW;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          f_req = 1'b0;
  logic [31:0]   f_addr = '0;
  logic          f_gnt, f_rvalid, f_err;
  logic [31:0]   f_rdata;
  logic          l_req = 1'b0, l_we = 1'b0, l_lock = 1'b0;
  logic [31:0]   l_addr = '0, l_wdata = '0;
  logic          l_gnt, l_rvalid, l_err;
  logic [31:0]   l_rdata;
  logic [DW-1:0] mem_addr;
  logic          mem_we;
  logic [31:0]   mem_wdata, mem_rdata;

  im_arbiter #(.DEPTH_W(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
    .f_rdata(f_rdata), .f_err(f_err),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_lock(l_lock), .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
    .l_err(l_err),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(int i);
    if (i == 0) return 32'h0badf00d;
    if (i == 2) return 32'h3c01ffff;
    return (i * 32'h01010101) ^ 32'ha5a50000;
  endfunction

  // Environment array driven by the DUT: combinational read, synchronous write.
  logic [31:0] env_mem [NW];
  bit          env_init = 1'b0;
  assign mem_rdata = env_mem[mem_addr];
  always @(posedge clk) begin
    if (!env_init) begin
      for (int i = 0; i < NW; i++) env_mem[i] <= init_word(i);
      env_init <= 1'b1;
    end else if (mem_we) begin
      env_mem[mem_addr] <= mem_wdata;
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, need 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: expected array contents and arbitration/response state.
  logic [31:0] ref_mem [NW];
  bit          ref_init = 1'b0;
  bit          m_prio, m_burst;
  int          m_beats;
  bit          e_frv, e_lrv, e_ferr, e_lerr;
  logic [31:0] e_fdata, e_ldata;
  bit          last_gf, last_gl;

  always @(negedge clk or negedge reset) begin
    bit          gf, gl, mis;
    logic [31:0] a;
    int          idx;
    if (!ref_init) begin
      for (int i = 0; i < NW; i++) ref_mem[i] = init_word(i);
      ref_init = 1'b1;
    end
    if (!reset) begin
      m_prio = 0; m_burst = 0; m_beats = 0;
      e_frv = 0; e_lrv = 0; last_gf = 0; last_gl = 0;
    end else begin
      chk("f_rvalid", f_rvalid, e_frv);
      chk("l_rvalid", l_rvalid, e_lrv);
      if (e_frv) begin
        chk("f_rdata", f_rdata, e_fdata);
        chk("f_err", f_err, e_ferr);
      end
      if (e_lrv) begin
        chk("l_rdata", l_rdata, e_ldata);
        chk("l_err", l_err, e_lerr);
      end
      if (!m_burst) begin
        if (f_req && l_req) begin gf = !m_prio; gl = m_prio; end
        else begin gf = f_req; gl = l_req; end
      end else begin
        gl = l_req && (m_beats < MB || !f_req);
        gf = !gl && f_req;
      end
      chk("f_gnt", f_gnt, gf);
      chk("l_gnt", l_gnt, gl);
      mis = 0; idx = 0;
      if (gf || gl) begin
        a = gl ? l_addr : f_addr;
        mis = (a % 4) != 0;
        idx = int'((a / 4) % NW);
        chk("mem_we", mem_we, gl && l_we && !mis);
        if (!mis) begin
          chk("mem_addr", mem_addr, idx);
          chk("mem_wdata", mem_wdata, l_wdata);
        end
      end else begin
        chk("mem_we_idle", mem_we, 0);
        chk("mem_addr_idle", mem_addr, 0);
        chk("mem_wdata_idle", mem_wdata, 0);
      end
      e_frv = gf; e_lrv = gl;
      if (gf) begin
        e_ferr = mis;
        e_fdata = mis ? 32'h0 : ref_mem[idx];
        m_prio = 1; m_burst = 0; m_beats = 0;
      end
      if (gl) begin
        e_lerr = mis;
        e_ldata = mis ? 32'h0 : (l_we ? l_wdata : ref_mem[idx]);
        if (l_we && !mis) ref_mem[idx] = l_wdata;
        m_prio = 0;
        if (!l_lock) begin m_burst = 0; m_beats = 0; end
        else if (!m_burst) begin m_burst = 1; m_beats = 1; end
        else if (m_beats < MB) m_beats++;
      end
      if (!gf && !gl && m_burst) begin
        m_burst = 0; m_beats = 0; m_prio = 0;
      end
      last_gf = gf; last_gl = gl;
    end
  end

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic at_neg();
    @(negedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    next_cycle();
    reset = 1'b1;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    if ($urandom_range(0, 3) == 0) a = {20'h0, 2'b00, 10'($urandom_range(0, NW - 1)), 2'b00} ;
    else a = 32'($urandom_range(0, 31)) << 2;
    a = a | ($urandom & 32'hFFFF_F000);
    if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
    return a;
  endfunction

  initial begin
    logic [5:0] pat;
    int         nf;
    bit         g_l [10];
    bit         g_f [10];
    int         l_before_f;
    bit         seen_f;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_f_rvalid", f_rvalid, 0);
    chk("rst_l_rvalid", l_rvalid, 0);
    chk("rst_f_err", f_err, 0);
    chk("rst_l_err", l_err, 0);
    chk("rst_f_rdata", f_rdata, 0);
    chk("rst_l_rdata", l_rdata, 0);
    reset = 1'b1;

    // Single fetch of word 2
    next_cycle();
    f_req = 1; f_addr = 32'h8;
    at_neg();
    chk("t1_f_gnt", f_gnt, 1);
    chk("t1_mem_addr", mem_addr, 2);
    next_cycle();
    f_req = 0;
    chk("t1_f_rvalid", f_rvalid, 1);
    chk("t1_f_rdata", f_rdata, 32'h3c01ffff);
    chk("t1_f_err", f_err, 0);
    chk("t1_l_rvalid", l_rvalid, 0);

    // Alternation from reset with both requesting
    do_reset();
    f_req = 1; f_addr = 32'h20;
    l_req = 1; l_addr = 32'h40; l_we = 0; l_lock = 0;
    pat = '0; nf = 0;
    for (int i = 0; i < 6; i++) begin
      at_neg();
      pat[i] = l_gnt;
      if (f_gnt) nf++;
      next_cycle();
    end
    f_req = 0; l_req = 0;
    chk("t2_pattern", pat, 6'b101010);
    chk("t2_fetch_count", nf, 3);

    // Loader write then fetch readback
    next_cycle();
    l_req = 1; l_we = 1; l_addr = 32'h10; l_wdata = 32'h12345678; l_lock = 0;
    at_neg();
    chk("t3_l_gnt", l_gnt, 1);
    chk("t3_mem_we", mem_we, 1);
    next_cycle();
    l_req = 0; l_we = 0;
    f_req = 1; f_addr = 32'h10;
    chk("t3_l_rvalid", l_rvalid, 1);
    chk("t3_l_rdata", l_rdata, 32'h12345678);
    next_cycle();
    f_req = 0;
    chk("t3_f_rdata", f_rdata, 32'h12345678);

    // Locked burst bounded by MAX_BURST
    do_reset();
    l_req = 1; l_lock = 1; l_we = 0; l_addr = 32'h100;
    for (int i = 0; i < 10; i++) begin
      at_neg();
      g_l[i] = l_gnt; g_f[i] = f_gnt;
      next_cycle();
      f_req = 1; f_addr = 32'h44;
    end
    f_req = 0; l_req = 0; l_lock = 0;
    l_before_f = 0; seen_f = 0;
    for (int i = 0; i < 10; i++) begin
      if (g_f[i]) seen_f = 1;
      else if (!seen_f && g_l[i]) l_before_f++;
    end
    chk("t4_l_before_f", l_before_f, 8);
    chk("t4_f_at_9th", g_f[8], 1);
    chk("t4_l_after_f", g_l[9], 1);

    // Misaligned fetch and loader write
    next_cycle();
    f_req = 1; f_addr = 32'h6;
    at_neg();
    chk("t5_f_gnt", f_gnt, 1);
    chk("t5_f_mem_we", mem_we, 0);
    next_cycle();
    f_req = 0;
    chk("t5_f_err", f_err, 1);
    chk("t5_f_rdata", f_rdata, 0);
    l_req = 1; l_we = 1; l_addr = 32'h3; l_wdata = 32'hdeadbeef;
    at_neg();
    chk("t5_l_gnt", l_gnt, 1);
    chk("t5_l_mem_we", mem_we, 0);
    next_cycle();
    chk("t5_l_err", l_err, 1);
    chk("t5_l_rdata", l_rdata, 0);
    l_we = 0; l_addr = 32'h0;
    next_cycle();
    l_req = 0;
    chk("t5_word0", l_rdata, 32'h0badf00d);

    // Reset between grant and response
    next_cycle();
    f_req = 1; f_addr = 32'h8;
    at_neg();
    chk("t6_f_gnt", f_gnt, 1);
    reset = 1'b0;
    next_cycle();
    chk("t6_f_rvalid", f_rvalid, 0);
    f_req = 0;
    next_cycle();
    reset = 1'b1;
    f_req = 1; f_addr = 32'h8;
    l_req = 1; l_addr = 32'h0; l_we = 0; l_lock = 0;
    at_neg();
    chk("t6_fetch_first", f_gnt, 1);
    next_cycle();
    f_req = 0;
    chk("t6_f_rvalid_after", f_rvalid, 1);
    chk("t6_f_rdata_after", f_rdata, 32'h3c01ffff);
    next_cycle();
    l_req = 0;

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      next_cycle();
      if (!f_req || last_gf) begin
        f_req = ($urandom_range(0, 99) < 60);
        f_addr = rand_addr();
      end
      if (!l_req || last_gl) begin
        l_req = ($urandom_range(0, 99) < 75);
        l_we = ($urandom_range(0, 2) == 0);
        l_lock = ($urandom_range(0, 99) < 70);
        l_addr = rand_addr();
        l_wdata = $urandom;
      end
    end
    next_cycle();
    f_req = 0; l_req = 0;
    repeat (3) next_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
